// File: rtl/stage_sequencer_pkg.sv
// Shared state encodings and default stage indices for the stage sequencer.
package stage_sequencer_pkg;

  typedef enum logic [1:0] {
    SeqIdle   = 2'd0,
    SeqRun    = 2'd1,
    SeqHalted = 2'd2
  } seq_state_e;

  localparam int unsigned STAGE_FETCH     = 0;
  localparam int unsigned STAGE_DECODE    = 1;
  localparam int unsigned STAGE_EXECUTE   = 2;
  localparam int unsigned STAGE_MEMORY    = 3;
  localparam int unsigned STAGE_WRITEBACK = 4;

endpackage

// File: rtl/stage_next_finder.sv
// Combinational priority search for the next non-skipped stage above the current one.
module stage_next_finder #(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned STAGE_W    = 3
) (
  input  logic [STAGE_W-1:0]    i_cur_stage,
  input  logic [NUM_STAGES-1:0] i_skip_mask,
  output logic [STAGE_W-1:0]    o_next_stage,
  output logic                  o_wrap
);

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    o_next_stage = '0;
    o_wrap       = 1'b1;
    for (int j = int'(NUM_STAGES) - 1; j >= 0; j--) begin
      if ((j > int'(i_cur_stage)) && !i_skip_mask[j]) begin
        o_next_stage = STAGE_W'(j);
        o_wrap       = 1'b0;
      end
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle CPU stage sequencer with skip mask, halt/resume and wrap strobe.
// Optional perf counters are enabled by defining STAGE_PERF_CNT_EN.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int unsigned NUM_STAGES   = STAGE_WRITEBACK + 1,
  parameter int unsigned STAGE_W      = 3,
  parameter int unsigned FETCH_STAGE  = STAGE_FETCH,
  parameter int unsigned MEMORY_STAGE = STAGE_MEMORY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  blocked,
  input  logic [NUM_STAGES-1:0] skip_mask,
  input  logic                  halt,
  output logic [STAGE_W-1:0]    out,
  output logic [NUM_STAGES-1:0] stage_onehot,
  output logic                  start_fetch,
  output logic                  start_memory,
  output logic                  cycle_done,
  output logic                  running,
  output logic [31:0]           stall_count,
  output logic [31:0]           instr_count
);

  localparam logic [STAGE_W-1:0]    FETCH_IDX = STAGE_W'(FETCH_STAGE);
  localparam logic [STAGE_W-1:0]    MEM_IDX   = STAGE_W'(MEMORY_STAGE);
  localparam logic [NUM_STAGES-1:0] FETCH_BIT = NUM_STAGES'(1) << FETCH_STAGE;

  seq_state_e            r_state, w_state_d;
  logic [STAGE_W-1:0]    r_out, w_out_d, w_next;
  logic [NUM_STAGES-1:0] r_onehot, w_onehot_d, w_skip_eff;
  logic                  r_start_fetch, w_start_fetch_d;
  logic                  r_start_memory, w_start_memory_d;
  logic                  r_cycle_done, w_cycle_done_d;
  logic                  r_running, w_running_d;
  logic                  w_wrap, w_illegal, w_enter;

  // The fetch stage can never be skipped.
  assign w_skip_eff = skip_mask & ~FETCH_BIT;
  assign w_illegal  = 32'(r_out) >= NUM_STAGES;

  stage_next_finder #(
    .NUM_STAGES (NUM_STAGES),
    .STAGE_W    (STAGE_W)
  ) u_next_finder (
    .i_cur_stage  (r_out),
    .i_skip_mask  (w_skip_eff),
    .o_next_stage (w_next),
    .o_wrap       (w_wrap)
  );

  always_comb begin
    w_state_d      = r_state;
    w_out_d        = r_out;
    w_enter        = 1'b0;
    w_cycle_done_d = 1'b0;
    case (r_state)
      SeqIdle: begin
        w_state_d = SeqRun;
        w_out_d   = FETCH_IDX;
        w_enter   = 1'b1;
      end
      SeqRun: begin
        if (w_illegal) begin
          w_out_d = FETCH_IDX;
          w_enter = 1'b1;
        end else if (!blocked) begin
          w_enter = 1'b1;
          if (w_wrap) begin
            w_out_d        = FETCH_IDX;
            w_cycle_done_d = 1'b1;
            // Halt only takes effect at an instruction boundary.
            if (halt) begin
              w_state_d = SeqHalted;
              w_enter   = 1'b0;
            end
          end else begin
            w_out_d = w_next;
          end
        end
      end
      SeqHalted: begin
        w_out_d = FETCH_IDX;
        if (!halt) begin
          w_state_d = SeqRun;
          w_enter   = 1'b1;
        end
      end
      default: begin
        w_state_d = SeqIdle;
        w_out_d   = FETCH_IDX;
      end
    endcase
    w_start_fetch_d  = w_enter && (w_out_d == FETCH_IDX);
    w_start_memory_d = w_enter && (w_out_d == MEM_IDX);
    w_running_d      = (w_state_d == SeqRun);
    w_onehot_d       = w_running_d ? (NUM_STAGES'(1) << w_out_d) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= SeqIdle;
      r_out          <= '0;
      r_onehot       <= '0;
      r_start_fetch  <= 1'b0;
      r_start_memory <= 1'b0;
      r_cycle_done   <= 1'b0;
      r_running      <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_out          <= w_out_d;
      r_onehot       <= w_onehot_d;
      r_start_fetch  <= w_start_fetch_d;
      r_start_memory <= w_start_memory_d;
      r_cycle_done   <= w_cycle_done_d;
      r_running      <= w_running_d;
    end
  end

  assign out          = r_out;
  assign stage_onehot = r_onehot;
  assign start_fetch  = r_start_fetch;
  assign start_memory = r_start_memory;
  assign cycle_done   = r_cycle_done;
  assign running      = r_running;

`ifdef STAGE_PERF_CNT_EN
  logic [31:0] r_stall_count, r_instr_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_count <= '0;
      r_instr_count <= '0;
    end else begin
      if ((r_state == SeqRun) && blocked) r_stall_count <= r_stall_count + 32'd1;
      if (w_cycle_done_d)                 r_instr_count <= r_instr_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
  assign instr_count = r_instr_count;
`else
  assign stall_count = '0;
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Randomized bench for stage_sequencer: a 5-stage and a 3-stage instance vs a behavioural model.
module tb_stage_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        blk_a = 1'b0, halt_a = 1'b0;
  logic [4:0]  skip_a = '0;
  logic [2:0]  out_a;
  logic [4:0]  oh_a;
  logic        sf_a, sm_a, cd_a, run_a;
  logic [31:0] stall_a, instr_a;

  logic        blk_b = 1'b0, halt_b = 1'b0;
  logic [2:0]  skip_b = '0;
  logic [1:0]  out_b;
  logic [2:0]  oh_b;
  logic        sf_b, sm_b, cd_b, run_b;
  logic [31:0] stall_b, instr_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode 0 idle, 1 run, 2 halted.
  int          m_mode[2];
  int          m_stage[2];
  bit          m_sf[2], m_sm[2], m_cd[2];
  logic [31:0] m_stall[2], m_instr[2];
  int          nst[2] = '{5, 3};
  int          mem[2] = '{3, 2};

  always #5 clk = ~clk;

  stage_sequencer u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .blocked      (blk_a),
    .skip_mask    (skip_a),
    .halt         (halt_a),
    .out          (out_a),
    .stage_onehot (oh_a),
    .start_fetch  (sf_a),
    .start_memory (sm_a),
    .cycle_done   (cd_a),
    .running      (run_a),
    .stall_count  (stall_a),
    .instr_count  (instr_a)
  );

  stage_sequencer #(
    .NUM_STAGES   (3),
    .STAGE_W      (2),
    .FETCH_STAGE  (0),
    .MEMORY_STAGE (2)
  ) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .blocked      (blk_b),
    .skip_mask    (skip_b),
    .halt         (halt_b),
    .out          (out_b),
    .stage_onehot (oh_b),
    .start_fetch  (sf_b),
    .start_memory (sm_b),
    .cycle_done   (cd_b),
    .running      (run_b),
    .stall_count  (stall_b),
    .instr_count  (instr_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k]  = 0;
      m_stage[k] = 0;
      m_sf[k]    = 0;
      m_sm[k]    = 0;
      m_cd[k]    = 0;
      m_stall[k] = '0;
      m_instr[k] = '0;
    end
  endtask

  task automatic model_step(input int k, input bit b, input logic [7:0] sk, input bit h);
    int j;
    m_sf[k] = 0;
    m_sm[k] = 0;
    m_cd[k] = 0;
    if (m_mode[k] == 0) begin
      m_mode[k]  = 1;
      m_stage[k] = 0;
      m_sf[k]    = 1;
    end else if (m_mode[k] == 2) begin
      if (!h) begin
        m_mode[k] = 1;
        m_sf[k]   = 1;
      end
    end else if (b) begin
      m_stall[k] = m_stall[k] + 1;
    end else begin
      j = m_stage[k] + 1;
      while (j < nst[k] && sk[j]) j++;
      if (j >= nst[k]) begin
        m_cd[k]    = 1;
        m_instr[k] = m_instr[k] + 1;
        m_stage[k] = 0;
        if (h) m_mode[k] = 2;
        else   m_sf[k]   = 1;
      end else begin
        m_stage[k] = j;
        m_sm[k]    = (j == mem[k]);
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_oh[2];
    logic [31:0] exp_stall[2], exp_instr[2];
    for (int k = 0; k < 2; k++) begin
      exp_oh[k] = (m_mode[k] == 1) ? (32'd1 << m_stage[k]) : 32'd0;
`ifdef STAGE_PERF_CNT_EN
      exp_stall[k] = m_stall[k];
      exp_instr[k] = m_instr[k];
`else
      exp_stall[k] = 32'd0;
      exp_instr[k] = 32'd0;
`endif
    end
    check("a.out",     32'(out_a),   32'(m_stage[0]));
    check("a.onehot",  32'(oh_a),    exp_oh[0]);
    check("a.fetch",   32'(sf_a),    32'(m_sf[0]));
    check("a.memory",  32'(sm_a),    32'(m_sm[0]));
    check("a.done",    32'(cd_a),    32'(m_cd[0]));
    check("a.running", 32'(run_a),   32'(m_mode[0] == 1));
    check("a.stalls",  stall_a,      exp_stall[0]);
    check("a.instrs",  instr_a,      exp_instr[0]);
    check("b.out",     32'(out_b),   32'(m_stage[1]));
    check("b.onehot",  32'(oh_b),    exp_oh[1]);
    check("b.fetch",   32'(sf_b),    32'(m_sf[1]));
    check("b.memory",  32'(sm_b),    32'(m_sm[1]));
    check("b.done",    32'(cd_b),    32'(m_cd[1]));
    check("b.running", 32'(run_b),   32'(m_mode[1] == 1));
    check("b.stalls",  stall_b,      exp_stall[1]);
    check("b.instrs",  instr_b,      exp_instr[1]);
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0, blk_a, 8'(skip_a), halt_a);
    model_step(1, blk_b, 8'(skip_b), halt_b);
    #1;
    check_all();
  endtask

  task automatic set_in(input bit b, input logic [4:0] sk, input bit h);
    blk_a  = b;
    blk_b  = b;
    skip_a = sk;
    skip_b = sk[2:0];
    halt_a = h;
    halt_b = h;
  endtask

  // Called just after a sampled edge; pulls reset between edges and releases before the next.
  task automatic async_reset();
    #1 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    #1 rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    check_all();
    #18 rst = 1'b1;

    set_in(0, 5'b00000, 0);
    repeat (6) step();

    for (int i = 0; i < 10 && m_stage[0] != 3; i++) step();
    set_in(1, 5'b00000, 0);
    repeat (3) step();
    set_in(0, 5'b00000, 0);
    repeat (3) step();

    set_in(0, 5'b01000, 0);
    repeat (10) step();
    set_in(0, 5'b11110, 0);
    repeat (4) step();

    set_in(0, 5'b00000, 0);
    for (int i = 0; i < 10 && m_stage[0] != 2; i++) step();
    set_in(0, 5'b00000, 1);
    repeat (4) step();
    set_in(0, 5'b00000, 0);
    repeat (3) step();

    for (int i = 0; i < 10 && m_stage[0] != 2; i++) step();
    async_reset();
    repeat (3) step();

    for (int i = 0; i < 2000; i++) begin
      blk_a  = ($urandom_range(0, 3) == 0);
      blk_b  = ($urandom_range(0, 3) == 0);
      skip_a = ($urandom_range(0, 1) == 0) ? 5'($urandom & $urandom) : 5'($urandom);
      skip_b = 3'($urandom & $urandom);
      if ($urandom_range(0, 9) == 0) halt_a = ~halt_a;
      if ($urandom_range(0, 9) == 0) halt_b = ~halt_b;
      step();
      if (i % 500 == 250) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
